// File: rtl/gpu_int_seq.sv
// rtl/gpu_int_seq.sv - GPU interrupt sequencer: edge latch, mask, priority, req/ack injection
module gpu_int_seq #(
  parameter int          NSRC      = 5,
  parameter logic [23:0] VEC_BASE  = 24'hF03000,
  parameter int          VEC_SHIFT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic            go,
  input  logic            flagwr,
  input  logic [31:0]     gpu_din,
  input  logic            int_ack,
  output logic            int_req,
  output logic [23:0]     int_addr,
  output logic [2:0]      int_num,
  output logic            imask,
  output logic [NSRC-1:0] int_ena,
  output logic [NSRC-1:0] int_lat
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [NSRC-1:0] r_src_d;
  logic [NSRC-1:0] r_lat;
  logic [NSRC-1:0] r_ena;
  logic            r_imask;
  logic            r_req;
  logic [2:0]      r_num;
  logic [23:0]     r_addr;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend;
  logic [2:0]      w_sel;
  logic [23:0]     w_vec;
  logic            w_launch;
  logic            w_ack_take;
  logic            w_unused_din;

  assign w_rise       = irq_src & ~r_src_d;
  assign w_clr        = flagwr ? gpu_din[13:9] : '0;
  assign w_pend       = r_lat & r_ena;
  assign w_vec        = VEC_BASE + ({21'b0, w_sel} << VEC_SHIFT);
  assign w_unused_din = ^{gpu_din[31:14], gpu_din[2:0]};

  // Highest pending index wins
  always_comb begin
    w_sel = 3'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_pend[i]) w_sel = i[2:0];
    end
  end

  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_ack_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go && !r_imask && (|w_pend)) begin
          w_next   = S_REQ;
          w_launch = 1'b1;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          w_next     = S_IDLE;
          w_ack_take = 1'b1;
        end else if (!go) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_src_d <= '0;
      r_lat   <= '0;
      r_ena   <= '0;
      r_imask <= 1'b0;
      r_req   <= 1'b0;
      r_num   <= 3'd0;
      r_addr  <= VEC_BASE;
    end else begin
      r_state <= w_next;
      r_src_d <= irq_src;
      // A set on the same edge as an INT_CLR takes precedence
      r_lat   <= (r_lat & ~w_clr) | (w_rise & r_ena);
      if (flagwr) r_ena <= gpu_din[8:4];
      if (w_ack_take) r_imask <= 1'b1;
      else if (flagwr && !gpu_din[3]) r_imask <= 1'b0;
      r_req <= (w_next == S_REQ);
      if (w_launch) begin
        r_num  <= w_sel;
        r_addr <= w_vec;
      end
    end
  end

  assign int_req  = r_req;
  assign int_addr = r_addr;
  assign int_num  = r_num;
  assign imask    = r_imask;
  assign int_ena  = r_ena;
  assign int_lat  = r_lat;

endmodule

// File: tb/tb_gpu_int_seq.sv
// tb/tb_gpu_int_seq.sv - scoreboard bench for gpu_int_seq
module tb_gpu_int_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  irq_src;
  logic        go;
  logic        flagwr;
  logic [31:0] gpu_din;
  logic        int_ack;
  logic        int_req;
  logic [23:0] int_addr;
  logic [2:0]  int_num;
  logic        imask;
  logic [4:0]  int_ena;
  logic [4:0]  int_lat;

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];
  logic        prev_req = 1'b0;

  gpu_int_seq dut (
    .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .go(go),
    .flagwr(flagwr), .gpu_din(gpu_din), .int_ack(int_ack),
    .int_req(int_req), .int_addr(int_addr), .int_num(int_num),
    .imask(imask), .int_ena(int_ena), .int_lat(int_lat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flag_write(input logic [4:0] ena, input logic [4:0] clr, input logic b3);
    gpu_din = {18'b0, clr, ena, b3, 3'b0};
    flagwr  = 1'b1;
    cyc();
    flagwr  = 1'b0;
    gpu_din = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!int_req && n < 10) begin
      cyc();
      n++;
    end
    checks++;
    if (!int_req) begin
      errors++;
      $display("FAIL %s timeout actual=0 expected=1", name);
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: every new request is matched against the scoreboard
  always @(negedge clk) begin
    if (int_req && !prev_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected actual=%0d/%h expected=none", int_num, int_addr);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        if ({int_num, int_addr} !== e) begin
          errors++;
          $display("FAIL req_vector actual=%0d/%h expected=%0d/%h",
                   int_num, int_addr, e[26:24], e[23:0]);
        end
      end
    end
    prev_req = int_req;
  end

  initial begin
    reset_n = 1'b0; irq_src = '0; go = 1'b0; flagwr = 1'b0;
    gpu_din = '0; int_ack = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // 1: reset values, then PIT source with latency
    chk("rst_req", int_req, 0);
    chk("rst_addr", int_addr, 24'hF03000);
    chk("rst_num", int_num, 0);
    chk("rst_imask", imask, 0);
    chk("rst_ena", int_ena, 0);
    chk("rst_lat", int_lat, 0);
    flag_write(5'h04, 5'h00, 1'b0);
    go = 1'b1;
    exp_q.push_back({3'd2, 24'hF03020});
    irq_src = 5'h04;
    cyc();
    chk("t1_lat", int_lat, 5'h04);
    chk("t1_req_early", int_req, 0);
    cyc();
    chk("t1_req", int_req, 1);
    ack();
    chk("t1_imask", imask, 1);
    chk("t1_req_drop", int_req, 0);
    flag_write(5'h04, 5'h04, 1'b0);
    irq_src = '0;
    cyc();
    chk("t1_idle", int_req, 0);

    // 2: priority among simultaneous rises
    flag_write(5'h1F, 5'h00, 1'b0);
    exp_q.push_back({3'd4, 24'hF03040});
    irq_src = 5'h12;
    wait_req("t2_req4");
    ack();
    chk("t2_imask", imask, 1);
    exp_q.push_back({3'd1, 24'hF03010});
    flag_write(5'h1F, 5'h10, 1'b0);
    wait_req("t2_req1");

    // 3: request frozen while a higher source latches
    irq_src = 5'h1A;
    cyc(); cyc();
    chk("t3_freeze_num", int_num, 1);
    chk("t3_freeze_addr", int_addr, 24'hF03010);
    chk("t3_lat", int_lat, 5'h0A);
    ack();
    exp_q.push_back({3'd3, 24'hF03030});
    flag_write(5'h1F, 5'h02, 1'b0);
    wait_req("t3_req3");
    ack();
    flag_write(5'h00, 5'h1F, 1'b0);
    irq_src = '0;
    cyc();

    // 4: disabled sources do not latch; set beats clear
    go = 1'b0;
    irq_src = 5'h01;
    cyc(); cyc();
    chk("t4_masked_lat", int_lat, 0);
    chk("t4_masked_req", int_req, 0);
    irq_src = '0;
    flag_write(5'h01, 5'h00, 1'b0);
    irq_src = 5'h01;
    cyc();
    chk("t4_lat", int_lat, 5'h01);
    flag_write(5'h01, 5'h01, 1'b0);
    chk("t4_clr", int_lat, 0);
    irq_src = '0;
    cyc();
    irq_src = 5'h01;
    flag_write(5'h01, 5'h01, 1'b0);
    chk("t4_set_wins", int_lat, 5'h01);

    // 5: go drop withdraws the request
    exp_q.push_back({3'd0, 24'hF03000});
    go = 1'b1;
    wait_req("t5_req");
    go = 1'b0;
    cyc();
    chk("t5_withdraw", int_req, 0);
    chk("t5_imask", imask, 0);
    chk("t5_lat", int_lat, 5'h01);
    exp_q.push_back({3'd0, 24'hF03000});
    go = 1'b1;
    wait_req("t5_rereq");

    // 6: async reset mid-handshake
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_req", int_req, 0);
    chk("t6_lat", int_lat, 0);
    chk("t6_ena", int_ena, 0);
    chk("t6_imask", imask, 0);
    chk("t6_addr", int_addr, 24'hF03000);
    go = 1'b0;
    irq_src = '0;
    cyc();
    reset_n = 1'b1;
    cyc(); cyc();

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
